// File: rtl/mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_responder_pkg
//   Shared word/address geometry for the memory responder slice.
//   MEM_BANDWIDTH is the number of bytes per memory word and MEM_ADDR_SIZE is
//   the width of the accelerator byte address. Both are overridable from the
//   command line; the defaults describe a 32-bit word on a 32-bit byte address.
//   The package derives the widths the RTL needs from those two macros and
//   provides small helpers for address decode and counter update.
// -----------------------------------------------------------------------------
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 4
`endif

`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif

package mem_responder_pkg;

  // Width of one memory word in bits.
  localparam int DATA_W = `MEM_BANDWIDTH * 8;

  // Width of the byte address coming from the accelerator.
  localparam int ADDR_W = `MEM_ADDR_SIZE;

  // Number of low byte-address bits that select a byte inside a word.
  localparam int WORD_SHIFT = $clog2(`MEM_BANDWIDTH);

  // Byte address to word index; the byte-in-word bits are simply discarded.
  function automatic logic [ADDR_W-1:0] word_index(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr >> WORD_SHIFT;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] count);
    return (count == 32'hFFFF_FFFF) ? count : count + 32'd1;
  endfunction

endpackage : mem_responder_pkg

// File: rtl/mem_resp_pipe.sv
// -----------------------------------------------------------------------------
// mem_resp_pipe
//   Fixed-length valid/data delay line used to return read data a constant
//   number of cycles after the read was sampled. Each stage carries a valid bit
//   and a data word; a stage's data register only loads when the word entering
//   it is valid, so the final stage keeps presenting the last returned word
//   during bubbles.
//
// Parameters
//   WIDTH   data word width in bits
//   DEPTH   number of register stages (cycles of delay), >= 1
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous reset, active-high; clears valid bits and data
//   valid_i  a word is entering the line this cycle
//   data_i   the word entering the line
//   valid_o  the word on data_o is being returned this cycle
//   data_o   most recently returned word
// -----------------------------------------------------------------------------
module mem_resp_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the line shifts by exactly one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) begin
        data_q[0] <= data_i;
      end
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        // Bubbles do not disturb the stored word, which gives the hold-last
        // behaviour on the output for free.
        if (valid_q[i-1]) begin
          data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule : mem_resp_pipe

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-port word-addressed memory model that answers accelerator requests
//   with a fixed read latency and never applies back-pressure. A bench-side
//   preload port writes the array directly. Illegal requests (read and write
//   together, out-of-range word, preload colliding with a write) are resolved
//   deterministically and flagged with a one-cycle protocol_error pulse.
//
// Parameters
//   DEPTH          number of MEM_BANDWIDTH-byte words in the array
//   READ_LATENCY   cycles from read sample to mem_valid, legal range 1..8
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous reset, ACTIVE-HIGH despite the name
//   mem_addr        accelerator byte address
//   mem_read        read request, sampled every cycle
//   mem_write       write request, sampled every cycle
//   mem_write_data  write word
//   preload_en      backdoor write strobe
//   preload_addr    backdoor byte address
//   preload_data    backdoor write word
//   mem_read_data   returned read word, holds between returns
//   mem_valid       mem_read_data is a fresh return this cycle
//   protocol_error  one-cycle pulse the cycle after an illegal request
//   rd_count        accepted in-range reads, saturating
//   wr_count        accepted in-range writes, saturating
// -----------------------------------------------------------------------------
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [`MEM_ADDR_SIZE-1:0]    mem_addr,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [`MEM_BANDWIDTH*8-1:0]  mem_write_data,
  input  logic                         preload_en,
  input  logic [`MEM_ADDR_SIZE-1:0]    preload_addr,
  input  logic [`MEM_BANDWIDTH*8-1:0]  preload_data,
  output logic [`MEM_BANDWIDTH*8-1:0]  mem_read_data,
  output logic                         mem_valid,
  output logic                         protocol_error,
  output logic [31:0]                  rd_count,
  output logic [31:0]                  wr_count
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] req_idx;
  logic [ADDR_W-1:0] pre_idx;
  logic              req_in_range;
  logic              pre_in_range;
  logic              wr_fire;
  logic              pre_fire;
  logic              rd_fire;
  logic              rd_hit;
  logic              err_d;
  logic [DATA_W-1:0] rd_word;
  logic [31:0]       rd_count_d;
  logic [31:0]       wr_count_d;

  logic              protocol_error_q;
  logic [31:0]       rd_count_q;
  logic [31:0]       wr_count_q;

  // NOTE: every signal driven here gets a default before any condition so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_idx      = word_index(mem_addr);
    pre_idx      = word_index(preload_addr);
    req_in_range = (req_idx < DEPTH_A);
    pre_in_range = (pre_idx < DEPTH_A);

    // A write always wins: it suppresses a same-cycle read and preload.
    wr_fire  = mem_write && req_in_range;
    pre_fire = preload_en && !mem_write && pre_in_range;

    // rd_fire launches a return (zero data when out of range); rd_hit is the
    // subset that actually reads the array and counts as accepted.
    rd_fire = mem_read && !mem_write;
    rd_hit  = rd_fire && req_in_range;

    err_d = (mem_read && mem_write)
          || ((mem_read || mem_write) && !req_in_range)
          || (preload_en && mem_write);

    // Array read happens in the sampling cycle, so a write committed at the
    // previous edge is already visible here.
    rd_word = '0;
    if (rd_hit) begin
      rd_word = mem_q[req_idx[IDX_W-1:0]];
    end

    rd_count_d = rd_count_q;
    if (rd_hit) begin
      rd_count_d = sat_inc(rd_count_q);
    end

    wr_count_d = wr_count_q;
    if (wr_fire) begin
      wr_count_d = sat_inc(wr_count_q);
    end
  end

  // NOTE: the array is deliberately left out of reset; contents survive a
  // reset and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[req_idx[IDX_W-1:0]] <= mem_write_data;
    end else if (pre_fire) begin
      mem_q[pre_idx[IDX_W-1:0]] <= preload_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Status and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      protocol_error_q <= 1'b0;
      rd_count_q       <= '0;
      wr_count_q       <= '0;
    end else begin
      protocol_error_q <= err_d;
      rd_count_q       <= rd_count_d;
      wr_count_q       <= wr_count_d;
    end
  end

  assign protocol_error = protocol_error_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

  // ---------------------------------------------------------------------------
  // Read return delay line; reset flushes in-flight reads.
  // ---------------------------------------------------------------------------
  mem_resp_pipe #(
    .WIDTH (DATA_W),
    .DEPTH (READ_LATENCY)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst_n),
    .valid_i (rd_fire),
    .data_i  (rd_word),
    .valid_o (mem_valid),
    .data_o  (mem_read_data)
  );

endmodule : mem_responder

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Drives two responders (READ_LATENCY 2 and 1) from the same request
//   stream. A behavioural model keeps the memory as an associative array and
//   the expected returns as a per-cycle schedule, and every cycle both DUTs
//   are compared with it. Directed steps add explicit checks for the key
//   scenarios; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH = 4096;
  localparam int MAXC  = 2048;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic              preload_en;
  logic [ADDR_W-1:0] preload_addr;
  logic [DATA_W-1:0] preload_data;

  logic [DATA_W-1:0] rd2, rd1;
  logic              v2, v1, e2, e1;
  logic [31:0]       rc2, rc1, wc2, wc1;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
    .mem_read_data(rd2), .mem_valid(v2), .protocol_error(e2),
    .rd_count(rc2), .wr_count(wc2)
  );

  mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .preload_en(preload_en), .preload_addr(preload_addr), .preload_data(preload_data),
    .mem_read_data(rd1), .mem_valid(v1), .protocol_error(e1),
    .rd_count(rc1), .wr_count(wc1)
  );

  // Reference model state
  logic [31:0] mdl_mem [int];
  bit          s2_v [MAXC];
  logic [31:0] s2_d [MAXC];
  bit          s1_v [MAXC];
  logic [31:0] s1_d [MAXC];
  bit          se   [MAXC];
  logic [31:0] last2, last1, mrc, mwc;
  int          cyc;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive(input bit r, input bit w, input int unsigned aw, input logic [31:0] wd,
                       input bit p, input int unsigned pw, input logic [31:0] pd);
    mem_read       = r;
    mem_write      = w;
    mem_addr       = (ADDR_W'(aw) << 2) | ADDR_W'($urandom_range(0, 3));
    mem_write_data = wd;
    preload_en     = p;
    preload_addr   = (ADDR_W'(pw) << 2) | ADDR_W'($urandom_range(0, 3));
    preload_data   = pd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
  endtask

  task automatic start_reset();
    rst_n = 1'b1;
    for (int c = cyc; c < MAXC; c++) begin
      s2_v[c] = 1'b0;
      s1_v[c] = 1'b0;
      se[c]   = 1'b0;
    end
    last2 = '0;
    last1 = '0;
    mrc   = '0;
    mwc   = '0;
  endtask

  // One clock: apply the request rules to the current inputs, take the edge,
  // then compare both DUTs against the model.
  task automatic cycle();
    int unsigned idx, pidx;
    bit          in_r, pin, err, rd;
    logic [31:0] rdata;
    if (!rst_n) begin
      idx   = mem_addr >> 2;
      pidx  = preload_addr >> 2;
      in_r  = idx < DEPTH;
      pin   = pidx < DEPTH;
      err   = (mem_read && mem_write) || ((mem_read || mem_write) && !in_r)
            || (preload_en && mem_write);
      rd    = mem_read && !mem_write;
      rdata = (rd && in_r) ? mdl_mem[int'(idx)] : 32'h0;
      if (rd && in_r && mrc != 32'hFFFF_FFFF) mrc++;
      if (mem_write && in_r) begin
        mdl_mem[int'(idx)] = mem_write_data;
        if (mwc != 32'hFFFF_FFFF) mwc++;
      end else if (preload_en && !mem_write && pin) begin
        mdl_mem[int'(pidx)] = preload_data;
      end
      if (rd) begin
        s2_v[cyc+2] = 1'b1; s2_d[cyc+2] = rdata;
        s1_v[cyc+1] = 1'b1; s1_d[cyc+1] = rdata;
      end
      se[cyc+1] = err;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s2_v[cyc]) last2 = s2_d[cyc];
    if (s1_v[cyc]) last1 = s1_d[cyc];
    chk("valid_l2", 32'(v2), 32'(s2_v[cyc]));
    chk("data_l2",  rd2, last2);
    chk("perr_l2",  32'(e2), 32'(se[cyc]));
    chk("rdcnt_l2", rc2, mrc);
    chk("wrcnt_l2", wc2, mwc);
    chk("valid_l1", 32'(v1), 32'(s1_v[cyc]));
    chk("data_l1",  rd1, last1);
    chk("perr_l1",  32'(e1), 32'(se[cyc]));
    chk("rdcnt_l1", rc1, mrc);
    chk("wrcnt_l1", wc1, mwc);
  endtask

  initial begin
    int c0;
    int rel;
    int vcount;
    checks = 0;
    errors = 0;
    cyc    = 0;
    idle();
    start_reset();

    // Reset state
    repeat (3) cycle();
    chk("rst_valid", 32'(v2), 32'd0);
    chk("rst_data",  rd2, 32'd0);
    chk("rst_rdcnt", rc2, 32'd0);
    chk("rst_wrcnt", wc2, 32'd0);
    rst_n = 1'b0;

    // Preload 0..3, then four back-to-back reads
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 0, 32'h0, 1'b1, i, 32'h11 * (i + 1));
      cycle();
    end
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1'b1, 1'b0, k, 32'h0, 1'b0, 0, 32'h0);
      else idle();
      cycle();
      rel = cyc - c0;
      chk("seq_valid", 32'(v2), 32'(rel >= 2 && rel <= 5));
      if (rel >= 2 && rel <= 5) chk("seq_data", rd2, 32'h11 * (rel - 1));
    end
    chk("seq_rdcnt", rc2, 32'd4);

    // Write then read of the same word
    drive(1'b0, 1'b1, 7, 32'hAB, 1'b0, 0, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 7, 32'h0, 1'b0, 0, 32'h0);
    cycle();
    chk("wr_rd_early", 32'(v2), 32'd0);
    idle();
    cycle();
    chk("wr_rd_valid", 32'(v2), 32'd1);
    chk("wr_rd_data",  rd2, 32'hAB);
    chk("wr_rd_wrcnt", wc2, 32'd1);

    // Read and write together: write only, read dropped
    drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 9, 32'h99);
    cycle();
    drive(1'b1, 1'b1, 9, 32'h5A5A_0009, 1'b0, 0, 32'h0);
    cycle();
    chk("rw_perr", 32'(e2), 32'd1);
    chk("rw_valid0", 32'(v2), 32'd0);
    idle();
    cycle();
    chk("rw_perr_end", 32'(e2), 32'd0);
    chk("rw_valid1", 32'(v2), 32'd0);
    cycle();
    chk("rw_valid2", 32'(v2), 32'd0);
    chk("rw_rdcnt", rc2, 32'd5);
    chk("rw_wrcnt", wc2, 32'd2);
    drive(1'b1, 1'b0, 9, 32'h0, 1'b0, 0, 32'h0);
    cycle();
    idle();
    cycle();
    chk("rw_word9", rd2, 32'h5A5A_0009);

    // Out-of-range read and write
    drive(1'b1, 1'b0, DEPTH, 32'h0, 1'b0, 0, 32'h0);
    cycle();
    chk("oor_rd_perr", 32'(e2), 32'd1);
    idle();
    cycle();
    chk("oor_rd_valid", 32'(v2), 32'd1);
    chk("oor_rd_data",  rd2, 32'h0);
    chk("oor_rd_perr_end", 32'(e2), 32'd0);
    drive(1'b0, 1'b1, DEPTH, 32'hDEAD_BEEF, 1'b0, 0, 32'h0);
    cycle();
    chk("oor_wr_perr",  32'(e2), 32'd1);
    chk("oor_wr_wrcnt", wc2, 32'd2);
    drive(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 32'h0);
    cycle();
    idle();
    cycle();
    chk("oor_wr_word0", rd2, 32'h11);
    chk("oor_rdcnt", rc2, 32'd7);

    // Preload colliding with a write
    drive(1'b0, 1'b0, 0, 32'h0, 1'b1, 11, 32'h0B);
    cycle();
    drive(1'b0, 1'b1, 10, 32'h1010, 1'b1, 11, 32'hBEEF);
    cycle();
    chk("pw_perr",  32'(e2), 32'd1);
    chk("pw_wrcnt", wc2, 32'd3);
    drive(1'b1, 1'b0, 11, 32'h0, 1'b0, 0, 32'h0);
    cycle();
    drive(1'b1, 1'b0, 10, 32'h0, 1'b0, 0, 32'h0);
    cycle();
    chk("pw_word11", rd2, 32'h0B);
    idle();
    cycle();
    chk("pw_word10", rd2, 32'h1010);

    // Reset with reads in flight
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, k, 32'h0, 1'b0, 0, 32'h0);
      cycle();
    end
    idle();
    start_reset();
    repeat (2) cycle();
    rst_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("flush_valid_l2", 32'(v2), 32'd0);
      chk("flush_valid_l1", 32'(v1), 32'd0);
    end
    chk("flush_rdcnt", rc2, 32'd0);
    chk("flush_wrcnt", wc2, 32'd0);

    // Latency-1 instance: 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 0, 32'h0, 1'b1, i, 32'hC0DE_0000 + i);
      cycle();
    end
    c0     = cyc;
    vcount = 0;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, 1'b0, k, 32'h0, 1'b0, 0, 32'h0);
      else idle();
      cycle();
      rel = cyc - c0;
      if (v1) vcount++;
      chk("l1_valid", 32'(v1), 32'(rel >= 1 && rel <= 16));
      if (rel >= 1 && rel <= 16) chk("l1_data", rd1, 32'hC0DE_0000 + rel - 1);
    end
    chk("l1_count", 32'(vcount), 32'd16);

    // Randomized traffic over words 0..31 plus occasional out-of-range words
    for (int i = 16; i < 32; i++) begin
      drive(1'b0, 1'b0, 0, 32'h0, 1'b1, i, $urandom);
      cycle();
    end
    for (int n = 0; n < 300; n++) begin
      int unsigned op, w, pw;
      op = $urandom_range(0, 11);
      w  = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 2) : $urandom_range(0, 31);
      pw = $urandom_range(0, 31);
      case (op)
        0, 1, 2, 3: drive(1'b1, 1'b0, w, 32'h0, 1'b0, 0, 32'h0);
        4, 5:       drive(1'b0, 1'b1, w, $urandom, 1'b0, 0, 32'h0);
        6:          drive(1'b0, 1'b0, 0, 32'h0, 1'b1, pw, $urandom);
        7:          drive(1'b1, 1'b1, w, $urandom, 1'b0, 0, 32'h0);
        8:          drive(1'b0, 1'b1, w, $urandom, 1'b1, pw, $urandom);
        9:          drive(1'b1, 1'b0, w, 32'h0, 1'b1, pw, $urandom);
        default:    idle();
      endcase
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_responder

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 4096, giving the number of MEM_BANDWIDTH-byte words stored.
REQ-002 SHALL have parameter READ_LATENCY, default 2, giving the cycles from read sample to mem_valid; legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-high (asserted = 1).
REQ-005 SHALL have port mem_addr, input, `MEM_ADDR_SIZE bits: byte address from the accelerator.
REQ-006 SHALL have port mem_read, input, 1 bit: read request, sampled every cycle.
REQ-007 SHALL have port mem_write, input, 1 bit: write request, sampled every cycle.
REQ-008 SHALL have port mem_write_data, input, `MEM_BANDWIDTH*8 bits: write word.
REQ-009 SHALL have port preload_en, input, 1 bit: bench backdoor write strobe.
REQ-010 SHALL have port preload_addr, input, `MEM_ADDR_SIZE bits: backdoor byte address.
REQ-011 SHALL have port preload_data, input, `MEM_BANDWIDTH*8 bits: backdoor write word.
REQ-012 SHALL have port mem_read_data, output, `MEM_BANDWIDTH*8 bits: read return word.
REQ-013 SHALL have port mem_valid, output, 1 bit: mem_read_data is valid this cycle.
REQ-014 SHALL have port protocol_error, output, 1 bit: one-cycle pulse on an illegal request.
REQ-015 SHALL have port rd_count, output, 32 bits: count of accepted reads.
REQ-016 SHALL have port wr_count, output, 32 bits: count of accepted writes.

Function
REQ-017 SHALL form the word index as mem_addr >> log2(`MEM_BANDWIDTH); low address bits are ignored.
REQ-018 SHALL accept one request per cycle with no back-pressure; the responder never stalls.
REQ-019 SHALL, on an accepted write, update the array at the end of the sampling cycle.
REQ-020 SHALL, on an accepted read, read the array in the sampling cycle and return that word with mem_valid=1 exactly READ_LATENCY cycles later.
REQ-021 SHALL keep back-to-back reads fully pipelined: N consecutive reads give N consecutive mem_valid cycles, in order.
REQ-022 SHALL return data for a read issued in the cycle after a write to the same word that reflects the write (write-then-read ordering).
REQ-023 SHALL hold mem_valid=0 and mem_read_data at its last value in cycles with no return.
REQ-024 SHALL, when mem_read and mem_write are both 1, perform only the write, drop the read and pulse protocol_error.
REQ-025 SHALL, for an index >= DEPTH, drop a write, return all-zero data for a read at normal latency and pulse protocol_error.
REQ-026 SHALL, when preload_en and mem_write occur in the same cycle, perform mem_write, drop the preload and pulse protocol_error.
REQ-027 SHALL let a preload alone write the array like a write, without changing wr_count.
REQ-028 SHALL increment rd_count and wr_count by 1 per accepted in-range request, saturating at 32'hFFFF_FFFF.

Reset
REQ-029 SHALL, while rst_n=1, force mem_valid=0, mem_read_data=0, protocol_error=0, rd_count=0, wr_count=0 and clear all pipeline valid bits.
REQ-030 SHALL discard in-flight reads when reset asserts mid-operation; no mem_valid pulse for them after release.
REQ-031 SHALL NOT reset the array contents.

Structure
REQ-032 SHALL take `MEM_BANDWIDTH and `MEM_ADDR_SIZE from the shared defines header; the module adds no new package types.
REQ-033 SHALL place the READ_LATENCY valid/data delay line in sub-module mem_resp_pipe, parameterized by width and depth.

Verification
REQ-034 SHALL check: preload words 0..3 with 0x11..0x44, then reads of words 0..3 on consecutive cycles -> mem_valid high for cycles 2..5 with data 0x11,0x22,0x33,0x44 and rd_count=4.
REQ-035 SHALL check: write 0xAB to word 7, then read word 7 in the next cycle -> 0xAB returned 2 cycles later and wr_count=1.
REQ-036 SHALL check: read and write to word 9 in the same cycle -> word 9 = write data, no mem_valid, one protocol_error pulse, rd_count unchanged.
REQ-037 SHALL check: read of word DEPTH -> zero data at latency 2 with one protocol_error pulse; a write to word DEPTH leaves the array unchanged.
REQ-038 SHALL check: 3 reads issued, then reset asserted one cycle later -> no mem_valid after release and counters=0.
REQ-039 SHALL check: READ_LATENCY=1 with 16 consecutive reads -> 16 contiguous mem_valid cycles with correct data.
